vending_change_controller: RTL and testbench
============================================

VENDING_CHANGE_CONTROLLER -- requirements
Module: vending_change_controller

Interface
REQ-001 The block SHALL have ports: clock, in, 1, the single clock; all state changes on the rising edge.
REQ-002 The block SHALL have ports: reset_L, in, 1, asynchronous active-low reset.
REQ-003 The block SHALL have ports: start, in, 1, begin a transaction; Cost is sampled in the same cycle.
REQ-004 The block SHALL have ports: Cost, in, 4, item price in units, 0..15.
REQ-005 The block SHALL have ports: coin_valid, in, 1, a coin is presented this cycle.
REQ-006 The block SHALL have ports: coin, in, 4, value of the presented coin.
REQ-007 The block SHALL have ports: cancel, in, 1, customer abort request.
REQ-008 The block SHALL have ports: stock_load, in, 1, load the change pool.
REQ-009 The block SHALL have ports: stock_in, in, 4, new change pool value.
REQ-010 The block SHALL have ports: busy, out, 1, high in every state except IDLE.
REQ-011 The block SHALL have ports: coin_accept, out, 1, combinational; high only in COLLECT when registered Paid < Cost_r and cancel = 0.
REQ-012 The block SHALL have ports: Paid, out, 4, accumulated escrow.
REQ-013 The block SHALL have ports: Remaining, out, 4, change pool contents.
REQ-014 The block SHALL have ports: dispense, out, 1, one-cycle vend pulse.
REQ-015 The block SHALL have ports: change_pulse, out, 1, one unit of change paid out this cycle.
REQ-016 The block SHALL have ports: refund_valid, out, 1, one-cycle pulse.
REQ-017 The block SHALL have ports: refund_amt, out, 4, value of the refund.
REQ-018 The block SHALL have ports: NotEnoughChange, out, 1, one-cycle shortage flag.
REQ-019 The block SHALL have ports: ExactAmount, out, 1, combinational; equals (Remaining == 0).
REQ-020 The block SHALL have ports: done, out, 1, one-cycle end-of-transaction pulse.

Function
REQ-021 The FSM SHALL have states IDLE, COLLECT, VEND, CHANGE, REFUND and DONE; Moore outputs SHALL be registered or decoded from state only, except coin_accept and ExactAmount.
REQ-022 In IDLE, stock_load SHALL set Remaining to stock_in, and start SHALL be ignored in that same cycle.
REQ-023 In IDLE, start with stock_load = 0 SHALL latch Cost into Cost_r, clear Paid to 0, and enter COLLECT.
REQ-024 stock_load SHALL be ignored in every state other than IDLE.
REQ-025 In COLLECT, cancel SHALL have highest priority and enter REFUND with refund_amt = Paid and NotEnoughChange = 0.
REQ-026 In COLLECT, if cancel = 0 and registered Paid >= Cost_r, the block SHALL compute owed = Paid - Cost_r (4-bit, never negative) and ignore any coin presented that cycle.
REQ-027 In the REQ-026 case, if owed > Remaining, the block SHALL enter REFUND with refund_amt = Paid and NotEnoughChange = 1 during the REFUND cycle.
REQ-028 In the REQ-026 case, if owed <= Remaining, the block SHALL latch owed and enter VEND.
REQ-029 Otherwise in COLLECT, coin_valid SHALL add coin to Paid, saturating at 15 and never wrapping.
REQ-030 Cost = 0 SHALL reach VEND one cycle after COLLECT entry, with owed = 0.
REQ-031 VEND SHALL last exactly one cycle with dispense = 1; next state SHALL be CHANGE if owed > 0, else DONE.
REQ-032 CHANGE SHALL last exactly owed cycles; each cycle SHALL assert change_pulse and decrement Remaining and owed by 1; exit to DONE when owed reaches 0.
REQ-033 REFUND SHALL last one cycle with refund_valid = 1 and SHALL NOT modify Remaining; next state SHALL be DONE.
REQ-034 DONE SHALL last one cycle with done = 1; next state SHALL be IDLE; Paid SHALL hold its value until the next start.
REQ-035 cancel, start and coin_valid SHALL be ignored in VEND, CHANGE, REFUND and DONE.
REQ-036 Inserted coins SHALL never be added to Remaining.
REQ-037 Latency SHALL be: Paid >= Cost_r observed at edge t gives dispense in cycle t+1, first change_pulse in t+2, and done in t+2+owed.

Reset
REQ-038 While reset_L = 0, the state SHALL be IDLE asynchronously.
REQ-039 While reset_L = 0, Paid, Cost_r, owed and Remaining SHALL be 0, so ExactAmount = 1.
REQ-040 While reset_L = 0, all pulse outputs SHALL be 0, busy SHALL be 0 and refund_amt SHALL be 0.
REQ-041 Reset asserted mid-transaction SHALL abandon the transaction with no refund or dispense pulse.
REQ-042 The first transition after reset_L deasserts SHALL occur on the next rising edge.

Verification
REQ-043 Bench SHALL cover: stock 5; Cost 3; coins 2, 2 -> Paid 4; dispense 1 cycle; 1 change_pulse; Remaining 4; done.
REQ-044 Bench SHALL cover: stock 0; Cost 3; coin 5 -> NotEnoughChange = 1 and refund_valid with refund_amt 5; no dispense; Remaining 0; ExactAmount = 1.
REQ-045 Bench SHALL cover: stock 3; Cost 7; coin 4, then cancel together with coin 3 -> refund_amt 4; coin ignored; no dispense.
REQ-046 Bench SHALL cover: Cost 1; coins 9, 9 in consecutive cycles -> second coin ignored because coin_accept = 0; Paid 9; owed 8 needs stock >= 8, else shortage refund of 9.
REQ-047 Bench SHALL cover: Cost 0 -> dispense on the second cycle after start, no change_pulse; and stock_load with start in IDLE -> pool loaded, start ignored.
REQ-048 Bench SHALL cover: reset_L pulsed low in CHANGE with owed 3 -> immediate IDLE, Remaining 0, no further change_pulse.

Source files
------------

// File: rtl/vending_change_controller.sv
// Vending change controller: collects coins against a latched price,
// vends, pays change one unit per cycle from a pool, or refunds escrow.
module vending_change_controller (
   input  logic       clock,
   input  logic       reset_L,
   input  logic       start,
   input  logic [3:0] Cost,
   input  logic       coin_valid,
   input  logic [3:0] coin,
   input  logic       cancel,
   input  logic       stock_load,
   input  logic [3:0] stock_in,
   output logic       busy,
   output logic       coin_accept,
   output logic [3:0] Paid,
   output logic [3:0] Remaining,
   output logic       dispense,
   output logic       change_pulse,
   output logic       refund_valid,
   output logic [3:0] refund_amt,
   output logic       NotEnoughChange,
   output logic       ExactAmount,
   output logic       done
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_COLLECT = 3'd1;
   localparam logic [2:0] S_VEND    = 3'd2;
   localparam logic [2:0] S_CHANGE  = 3'd3;
   localparam logic [2:0] S_REFUND  = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   logic [2:0] state_q, state_d;
   logic [3:0] paid_q, paid_d;
   logic [3:0] cost_q, cost_d;
   logic [3:0] owed_q, owed_d;
   logic [3:0] remain_q, remain_d;
   logic       nec_q, nec_d;

   logic [3:0] owed_calc;
   logic [4:0] paid_sum;

   assign owed_calc = paid_q - cost_q;
   assign paid_sum  = {1'b0, paid_q} + {1'b0, coin};

   always_comb begin
      state_d  = state_q;
      paid_d   = paid_q;
      cost_d   = cost_q;
      owed_d   = owed_q;
      remain_d = remain_q;
      nec_d    = nec_q;
      case (state_q)
         S_IDLE: begin
            if (stock_load) begin
               remain_d = stock_in;
            end else if (start) begin
               cost_d  = Cost;
               paid_d  = 4'd0;
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (cancel) begin
               nec_d   = 1'b0;
               state_d = S_REFUND;
            end else if (paid_q >= cost_q) begin
               // Refuse the sale rather than short-change the customer.
               if (owed_calc > remain_q) begin
                  nec_d   = 1'b1;
                  state_d = S_REFUND;
               end else begin
                  owed_d  = owed_calc;
                  state_d = S_VEND;
               end
            end else if (coin_valid) begin
               paid_d = paid_sum[4] ? 4'hF : paid_sum[3:0];
            end
         end
         S_VEND: begin
            state_d = (owed_q != 4'd0) ? S_CHANGE : S_DONE;
         end
         S_CHANGE: begin
            remain_d = remain_q - 4'd1;
            owed_d   = owed_q - 4'd1;
            if (owed_q == 4'd1) begin
               state_d = S_DONE;
            end
         end
         S_REFUND: state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_q  <= S_IDLE;
         paid_q   <= 4'd0;
         cost_q   <= 4'd0;
         owed_q   <= 4'd0;
         remain_q <= 4'd0;
         nec_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         paid_q   <= paid_d;
         cost_q   <= cost_d;
         owed_q   <= owed_d;
         remain_q <= remain_d;
         nec_q    <= nec_d;
      end
   end

   assign busy            = (state_q != S_IDLE);
   assign coin_accept     = (state_q == S_COLLECT) && (paid_q < cost_q)
                            && !cancel;
   assign Paid            = paid_q;
   assign Remaining       = remain_q;
   assign dispense        = (state_q == S_VEND);
   assign change_pulse    = (state_q == S_CHANGE);
   assign refund_valid    = (state_q == S_REFUND);
   assign refund_amt      = (state_q == S_REFUND) ? paid_q : 4'd0;
   assign NotEnoughChange = (state_q == S_REFUND) && nec_q;
   assign ExactAmount     = (remain_q == 4'd0);
   assign done            = (state_q == S_DONE);

endmodule

// File: tb/tb_vending_change_controller.sv
// Bench for vending_change_controller: hand-derived vector table,
// random transactions against a price/escrow model, reset corner cases.
module tb_vending_change_controller;

   logic       clock;
   logic       reset_L;
   logic       start;
   logic [3:0] Cost;
   logic       coin_valid;
   logic [3:0] coin;
   logic       cancel;
   logic       stock_load;
   logic [3:0] stock_in;
   logic       busy;
   logic       coin_accept;
   logic [3:0] Paid;
   logic [3:0] Remaining;
   logic       dispense;
   logic       change_pulse;
   logic       refund_valid;
   logic [3:0] refund_amt;
   logic       NotEnoughChange;
   logic       ExactAmount;
   logic       done;

   int checks   = 0;
   int failures = 0;

   vending_change_controller dut (
      .clock(clock), .reset_L(reset_L), .start(start), .Cost(Cost),
      .coin_valid(coin_valid), .coin(coin), .cancel(cancel),
      .stock_load(stock_load), .stock_in(stock_in), .busy(busy),
      .coin_accept(coin_accept), .Paid(Paid), .Remaining(Remaining),
      .dispense(dispense), .change_pulse(change_pulse),
      .refund_valid(refund_valid), .refund_amt(refund_amt),
      .NotEnoughChange(NotEnoughChange), .ExactAmount(ExactAmount),
      .done(done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int stock;
      int cost;
      int n;
      int cv[6];
      int cval[6];
      int cancel_at;
   } stim_t;

   typedef struct {
      int disp;
      int dispc;
      int chg;
      int rfd;
      int ramt;
      int nec;
      int rem;
      int paid;
      int acc;
      int donec;
      int exact;
   } res_t;

   typedef struct {
      stim_t s;
      res_t  e;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   function automatic stim_t mks(int st, int co, int c0, int c1, int ca);
      stim_t s;
      s.stock = st;
      s.cost  = co;
      s.n     = 2;
      for (int i = 0; i < 6; i++) begin
         s.cv[i]   = 0;
         s.cval[i] = 0;
      end
      s.cv[0]   = (c0 >= 0) ? 1 : 0;
      s.cval[0] = (c0 >= 0) ? c0 : 0;
      s.cv[1]   = (c1 >= 0) ? 1 : 0;
      s.cval[1] = (c1 >= 0) ? c1 : 0;
      s.cancel_at = ca;
      return s;
   endfunction

   function automatic res_t mkr(int disp, int dispc, int chg, int rfd,
                                int ramt, int nec, int rem, int paid,
                                int acc, int donec);
      res_t r;
      r.disp  = disp;  r.dispc = dispc; r.chg  = chg;  r.rfd  = rfd;
      r.ramt  = ramt;  r.nec   = nec;   r.rem  = rem;  r.paid = paid;
      r.acc   = acc;   r.donec = donec; r.exact = (rem == 0) ? 1 : 0;
      return r;
   endfunction

   // Price/escrow model: walk the collect phase, then derive the outcome
   // and its timing from the owed amount.
   function automatic res_t model(stim_t s);
      res_t r;
      int paid, owed, k;
      bit vend;
      paid = 0; owed = 0; k = 0; vend = 0;
      r = mkr(0, -1, 0, 0, 0, 0, 0, 0, 0, -1);
      for (int c = 0; c < 64; c++) begin
         if (c == s.cancel_at) begin
            r.rfd = 1; r.ramt = paid; k = c;
            break;
         end
         if (paid >= s.cost) begin
            owed = paid - s.cost;
            if (owed > s.stock) begin
               r.rfd = 1; r.ramt = paid; r.nec = 1;
            end else begin
               vend = 1;
            end
            k = c;
            break;
         end
         r.acc++;
         if (c < s.n && s.cv[c] != 0) begin
            paid = paid + s.cval[c];
            if (paid > 15) paid = 15;
         end
      end
      r.paid = paid;
      if (vend) begin
         r.disp  = 1;
         r.dispc = k + 1;
         r.chg   = owed;
         r.rem   = s.stock - owed;
         r.donec = k + 2 + owed;
      end else begin
         r.rem   = s.stock;
         r.donec = k + 2;
      end
      r.exact = (r.rem == 0) ? 1 : 0;
      return r;
   endfunction

   task automatic run_txn(input stim_t s, output res_t o);
      bit fin;
      fin = 0;
      o = mkr(0, -1, 0, 0, 0, 0, 0, 0, 0, -1);
      @(posedge clock); #1;
      stock_load = 1'b1;
      stock_in   = 4'(s.stock);
      @(posedge clock); #1;
      stock_load = 1'b0;
      start      = 1'b1;
      Cost       = 4'(s.cost);
      @(posedge clock); #1;
      start = 1'b0;
      for (int c = 0; c < 64 && !fin; c++) begin
         if (c < s.n && c < 6) begin
            coin_valid = (s.cv[c] != 0);
            coin       = 4'(s.cval[c]);
         end else begin
            coin_valid = 1'b0;
            coin       = 4'd0;
         end
         cancel = (c == s.cancel_at);
         #1;
         if (coin_accept) o.acc++;
         if (dispense) begin
            o.disp++;
            o.dispc = c;
         end
         if (change_pulse) o.chg++;
         if (refund_valid) begin
            o.rfd++;
            o.ramt = int'(refund_amt);
         end
         if (NotEnoughChange) o.nec++;
         if (done) begin
            o.donec = c;
            fin = 1;
         end
         @(posedge clock); #1;
      end
      coin_valid = 1'b0;
      coin       = 4'd0;
      cancel     = 1'b0;
      chk("txn_timeout", int'(fin), 1);
      o.rem   = int'(Remaining);
      o.paid  = int'(Paid);
      o.exact = int'(ExactAmount);
   endtask

   task automatic compare(input string t, input res_t o, input res_t e);
      chk({t, ".dispense"}, o.disp, e.disp);
      chk({t, ".disp_cycle"}, o.dispc, e.dispc);
      chk({t, ".change_pulses"}, o.chg, e.chg);
      chk({t, ".refund_valid"}, o.rfd, e.rfd);
      chk({t, ".refund_amt"}, o.ramt, e.ramt);
      chk({t, ".not_enough"}, o.nec, e.nec);
      chk({t, ".remaining"}, o.rem, e.rem);
      chk({t, ".paid"}, o.paid, e.paid);
      chk({t, ".accept_cycles"}, o.acc, e.acc);
      chk({t, ".done_cycle"}, o.donec, e.donec);
      chk({t, ".exact"}, o.exact, e.exact);
   endtask

   vec_t tbl[8];

   initial begin
      res_t  o;
      stim_t s;
      int    hits;

      tbl[0].s = mks(5, 3, 2, 2, 6);
      tbl[0].e = mkr(1, 3, 1, 0, 0, 0, 4, 4, 2, 5);
      tbl[1].s = mks(0, 3, 5, -1, 6);
      tbl[1].e = mkr(0, -1, 0, 1, 5, 1, 0, 5, 1, 3);
      tbl[2].s = mks(3, 7, 4, 3, 1);
      tbl[2].e = mkr(0, -1, 0, 1, 4, 0, 3, 4, 1, 3);
      tbl[3].s = mks(8, 1, 9, 9, 6);
      tbl[3].e = mkr(1, 2, 8, 0, 0, 0, 0, 9, 1, 11);
      tbl[4].s = mks(7, 1, 9, 9, 6);
      tbl[4].e = mkr(0, -1, 0, 1, 9, 1, 7, 9, 1, 3);
      tbl[5].s = mks(2, 0, 5, -1, 6);
      tbl[5].e = mkr(1, 1, 0, 0, 0, 0, 2, 0, 0, 2);
      tbl[6].s = mks(15, 15, 9, 9, 6);
      tbl[6].e = mkr(1, 3, 0, 0, 0, 0, 15, 15, 2, 4);
      tbl[7].s = mks(4, 5, 3, -1, 0);
      tbl[7].e = mkr(0, -1, 0, 1, 0, 0, 4, 0, 0, 2);

      reset_L    = 1'b0;
      start      = 1'b0;
      Cost       = 4'd0;
      coin_valid = 1'b0;
      coin       = 4'd0;
      cancel     = 1'b0;
      stock_load = 1'b0;
      stock_in   = 4'd0;
      #2;
      chk("rst.busy", int'(busy), 0);
      chk("rst.paid", int'(Paid), 0);
      chk("rst.remaining", int'(Remaining), 0);
      chk("rst.exact", int'(ExactAmount), 1);
      chk("rst.pulses", int'({dispense, change_pulse, refund_valid,
                               NotEnoughChange, done, coin_accept}), 0);
      chk("rst.refund_amt", int'(refund_amt), 0);
      @(posedge clock); #1;
      reset_L = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_txn(tbl[i].s, o);
         compare($sformatf("vec%0d", i), o, tbl[i].e);
      end

      for (int i = 0; i < 40; i++) begin
         s.stock = int'($urandom_range(0, 15));
         s.cost  = int'($urandom_range(0, 15));
         s.n     = int'($urandom_range(0, 6));
         for (int j = 0; j < 6; j++) begin
            s.cv[j]   = int'($urandom_range(0, 3) != 0);
            s.cval[j] = int'($urandom_range(0, 15));
         end
         s.cancel_at = int'($urandom_range(0, s.n));
         run_txn(s, o);
         compare($sformatf("rnd%0d", i), o, model(s));
      end

      // stock_load beats start in IDLE; ignored once a sale is open.
      @(posedge clock); #1;
      stock_load = 1'b1;
      stock_in   = 4'd9;
      start      = 1'b1;
      Cost       = 4'd2;
      @(posedge clock); #1;
      stock_load = 1'b0;
      start      = 1'b0;
      chk("ld_start.busy", int'(busy), 0);
      chk("ld_start.remaining", int'(Remaining), 9);
      start = 1'b1;
      Cost  = 4'd4;
      @(posedge clock); #1;
      start      = 1'b0;
      stock_load = 1'b1;
      stock_in   = 4'd1;
      coin_valid = 1'b1;
      coin       = 4'd2;
      chk("ld_busy.busy", int'(busy), 1);
      chk("ld_busy.accept", int'(coin_accept), 1);
      @(posedge clock); #1;
      stock_load = 1'b0;
      coin_valid = 1'b0;
      chk("ld_busy.remaining", int'(Remaining), 9);
      chk("ld_busy.paid", int'(Paid), 2);
      cancel = 1'b1;
      @(posedge clock); #1;
      cancel = 1'b0;
      chk("ld_busy.refund_valid", int'(refund_valid), 1);
      chk("ld_busy.refund_amt", int'(refund_amt), 2);
      chk("ld_busy.not_enough", int'(NotEnoughChange), 0);
      @(posedge clock); #1;
      chk("ld_busy.done", int'(done), 1);
      @(posedge clock); #1;
      chk("ld_busy.idle", int'(busy), 0);

      // Reset during change payout with owed 3.
      stock_load = 1'b1;
      stock_in   = 4'd6;
      @(posedge clock); #1;
      stock_load = 1'b0;
      start      = 1'b1;
      Cost       = 4'd2;
      @(posedge clock); #1;
      start      = 1'b0;
      coin_valid = 1'b1;
      coin       = 4'd5;
      @(posedge clock); #1;
      coin_valid = 1'b0;
      @(posedge clock); #1;
      chk("rst_chg.dispense", int'(dispense), 1);
      @(posedge clock); #1;
      chk("rst_chg.in_change", int'(change_pulse), 1);
      chk("rst_chg.rem_before", int'(Remaining), 6);
      #2;
      reset_L = 1'b0;
      #1;
      chk("rst_chg.busy", int'(busy), 0);
      chk("rst_chg.remaining", int'(Remaining), 0);
      chk("rst_chg.paid", int'(Paid), 0);
      chk("rst_chg.exact", int'(ExactAmount), 1);
      chk("rst_chg.pulses", int'({dispense, change_pulse, refund_valid,
                                   done}), 0);
      @(posedge clock); #1;
      reset_L = 1'b1;
      hits = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         if (change_pulse || dispense || refund_valid || done || busy)
            hits++;
      end
      chk("rst_chg.quiet", hits, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
